timer_compare: RTL and testbench

TIMER_COMPARE -- requirements
Module: timer_compare

---
 rtl/timer_compare.sv | 136 +++++++++++++
 tb/tb_timer_compare.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_compare.sv
// Compare-match timer on a simple local bus: fires when the free-running count reaches CMP,
// optionally reloading CMP by PERIOD for periodic operation.
module timer_compare #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [AWIDTH-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata,
   input  logic [31:0]       count,
   output logic              irq
);

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrCmp    = 2'd1;
   localparam logic [1:0] AddrPeriod = 2'd2;
   localparam logic [1:0] AddrStatus = 2'd3;

   localparam int unsigned CtrlEn       = 0;
   localparam int unsigned CtrlPeriodic = 1;
   localparam int unsigned CtrlIe       = 2;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] period_q, period_d;
   logic        pend_q, pend_d;
   logic        ovr_q, ovr_d;

   logic [1:0]  reg_idx;
   logic [31:0] wdata32;
   logic        bus_wr;
   logic        wr_ctrl, wr_cmp, wr_period, wr_status;
   logic [31:0] cmp_diff;
   logic        reached;
   logic        fire;
   logic        reload;
   logic [31:0] rdata32;

   assign reg_idx = addr[3:2];
   assign wdata32 = wdata[31:0];
   assign bus_wr  = sel & we;

   assign wr_ctrl   = bus_wr && (reg_idx == AddrCtrl);
   assign wr_cmp    = bus_wr && (reg_idx == AddrCmp);
   assign wr_period = bus_wr && (reg_idx == AddrPeriod);
   assign wr_status = bus_wr && (reg_idx == AddrStatus);

   // Sign of the modular difference keeps the compare correct across count wrap.
   assign cmp_diff = count - cmp_q;
   assign reached  = ~cmp_diff[31];

   assign fire   = ctrl_q[CtrlEn] & reached & ~wr_cmp & ~wr_ctrl;
   assign reload = ctrl_q[CtrlPeriodic] && (period_q != 32'd0);

   always_comb begin
      ctrl_d   = ctrl_q;
      cmp_d    = cmp_q;
      period_d = period_q;
      pend_d   = pend_q;
      ovr_d    = ovr_q;

      if (wr_ctrl) begin
         ctrl_d = wdata32[2:0];
      end
      if (wr_cmp) begin
         cmp_d = wdata32;
      end
      if (wr_period) begin
         period_d = wdata32;
      end
      if (wr_status) begin
         if (wdata32[0]) pend_d = 1'b0;
         if (wdata32[1]) ovr_d  = 1'b0;
      end

      // Hardware sets are applied last so they win over a same-cycle W1C.
      if (fire) begin
         pend_d = 1'b1;
         if (pend_q) begin
            ovr_d = 1'b1;
         end
         if (reload) begin
            cmp_d = cmp_q + period_q;
         end else begin
            ctrl_d[CtrlEn] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= 3'b000;
         cmp_q    <= 32'hFFFF_FFFF;
         period_q <= 32'd0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         cmp_q    <= cmp_d;
         period_q <= period_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      rdata32 = 32'd0;
      if (sel && !we) begin
         unique case (reg_idx)
            AddrCtrl:   rdata32 = {29'd0, ctrl_q};
            AddrCmp:    rdata32 = cmp_q;
            AddrPeriod: rdata32 = period_q;
            AddrStatus: rdata32 = {30'd0, ovr_q, pend_q};
            default:    rdata32 = 32'd0;
         endcase
      end
   end

   assign rdata = XLEN'(rdata32);

   // Both operands are flops, so irq has no path from the bus inputs.
   assign irq = pend_q & ctrl_q[CtrlIe];

   logic unused_addr;
   assign unused_addr = ^{addr[AWIDTH-1:4], addr[1:0]};

   if (XLEN > 32) begin : g_wide_data
      logic unused_wdata;
      assign unused_wdata = ^wdata[XLEN-1:32];
   end

endmodule

// File: tb/tb_timer_compare.sv
// Directed self-checking bench for timer_compare: one-shot, skip, wrap, periodic,
// collision, catch-up and reset cases with hand-computed expectations.
module tb_timer_compare;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned AWIDTH = 32;

   localparam logic [AWIDTH-1:0] ACtrl   = 'h0;
   localparam logic [AWIDTH-1:0] ACmp    = 'h4;
   localparam logic [AWIDTH-1:0] APeriod = 'h8;
   localparam logic [AWIDTH-1:0] AStatus = 'hC;

   logic              clk;
   logic              rst;
   logic              sel;
   logic              we;
   logic [AWIDTH-1:0] addr;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   rdata;
   logic [31:0]       count;
   logic              irq;

   int checks;
   int failures;

   timer_compare #(
      .XLEN   (XLEN),
      .AWIDTH (AWIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .count (count),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [AWIDTH-1:0] a, input logic [31:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = XLEN'(d);
      tick();
      sel   = 1'b0;
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic read_chk(input string tag, input logic [AWIDTH-1:0] a,
                           input logic [31:0] exp);
      sel  = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      chk(tag, rdata[31:0], exp);
      sel  = 1'b0;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst   = 1'b1;
      sel   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      count = 32'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      read_chk("rst_ctrl", ACtrl, 32'h0);
      read_chk("rst_cmp", ACmp, 32'hFFFF_FFFF);
      read_chk("rst_period", APeriod, 32'h0);
      read_chk("rst_status", AStatus, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      // One-shot with interrupt enabled
      bus_write(ACmp, 32'd100);
      bus_write(ACtrl, 32'h5);
      count = 32'd96;
      tick();
      read_chk("os_before", AStatus, 32'h0);
      count = 32'd100;
      tick();
      read_chk("os_pend", AStatus, 32'h1);
      chk("os_irq", {31'd0, irq}, 32'd1);
      read_chk("os_en_clr", ACtrl, 32'h4);
      count = 32'd104;
      tick();
      read_chk("os_no_refire", AStatus, 32'h1);
      bus_write(AStatus, 32'h3);
      read_chk("os_w1c", AStatus, 32'h0);
      chk("os_irq_clr", {31'd0, irq}, 32'd0);

      // Skipped count value, IE off
      bus_write(ACmp, 32'd102);
      count = 32'd100;
      bus_write(ACtrl, 32'h1);
      tick();
      read_chk("skip_before", AStatus, 32'h0);
      count = 32'd104;
      tick();
      read_chk("skip_fire", AStatus, 32'h1);
      chk("skip_irq_masked", {31'd0, irq}, 32'd0);
      read_chk("skip_en_clr", ACtrl, 32'h0);
      bus_write(AStatus, 32'h1);

      // Wrap-safe compare
      bus_write(ACmp, 32'h0000_0002);
      count = 32'hFFFF_FFFC;
      bus_write(ACtrl, 32'h1);
      tick();
      read_chk("wrap_nofire", AStatus, 32'h0);
      count = 32'h0000_0004;
      tick();
      read_chk("wrap_fire", AStatus, 32'h1);
      bus_write(AStatus, 32'h1);

      // Periodic with overrun
      count = 32'd0;
      bus_write(ACmp, 32'd1000);
      bus_write(APeriod, 32'd500);
      bus_write(ACtrl, 32'h7);
      count = 32'd1000;
      tick();
      read_chk("per_cmp1", ACmp, 32'd1500);
      read_chk("per_ctrl", ACtrl, 32'h7);
      read_chk("per_pend", AStatus, 32'h1);
      count = 32'd1200;
      tick();
      read_chk("per_cmp_hold", ACmp, 32'd1500);
      count = 32'd1500;
      tick();
      read_chk("per_ovr", AStatus, 32'h3);
      read_chk("per_cmp2", ACmp, 32'd2000);
      chk("per_irq", {31'd0, irq}, 32'd1);

      // Collisions: CMP write blocks fire; hardware set beats W1C
      bus_write(AStatus, 32'h3);
      count = 32'd0;
      bus_write(ACmp, 32'd1000);
      count = 32'd1000;
      bus_write(ACmp, 32'd2000);
      read_chk("col_nofire", AStatus, 32'h0);
      read_chk("col_cmp", ACmp, 32'd2000);
      count = 32'd2000;
      bus_write(AStatus, 32'h1);
      read_chk("col_set_wins", AStatus, 32'h1);
      read_chk("col_cmp_reload", ACmp, 32'd2500);
      count = 32'd2500;
      bus_write(AStatus, 32'h3);
      read_chk("col_ovr_wins", AStatus, 32'h3);

      // Reset mid-operation beats a concurrent write; rdata is 0 during a write
      chk("pre_rst_irq", {31'd0, irq}, 32'd1);
      rst   = 1'b1;
      sel   = 1'b1;
      we    = 1'b1;
      addr  = ACmp;
      wdata = XLEN'(32'd5);
      #1;
      chk("rdata_on_write", rdata[31:0], 32'd0);
      tick();
      rst   = 1'b0;
      sel   = 1'b0;
      we    = 1'b0;
      chk("mid_rst_irq", {31'd0, irq}, 32'd0);
      read_chk("mid_rst_ctrl", ACtrl, 32'h0);
      read_chk("mid_rst_cmp", ACmp, 32'hFFFF_FFFF);
      read_chk("mid_rst_status", AStatus, 32'h0);
      read_chk("mid_rst_period", APeriod, 32'h0);

      // Unused CTRL bits read 0
      bus_write(ACtrl, 32'hFFFF_FFF8);
      read_chk("ctrl_mask", ACtrl, 32'h0);

      // Periodic catch-up: one fire per cycle until CMP passes count
      count = 32'd0;
      bus_write(ACmp, 32'd100);
      bus_write(APeriod, 32'd10);
      bus_write(ACtrl, 32'h3);
      count = 32'd135;
      tick();
      read_chk("cu_cmp110", ACmp, 32'd110);
      tick();
      read_chk("cu_cmp120", ACmp, 32'd120);
      tick();
      read_chk("cu_cmp130", ACmp, 32'd130);
      tick();
      read_chk("cu_cmp140", ACmp, 32'd140);
      tick();
      read_chk("cu_cmp_stop", ACmp, 32'd140);
      read_chk("cu_status", AStatus, 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
